// File: rtl/seg7_scan.sv
// seg7_scan
// ---------
// Display back-end for the calculator. Reassembles the serialized nibble
// stream coming from the display serializer into a 16-bit display buffer
// and time-multiplexes that buffer onto a 4-digit common-anode 7-segment
// display.
//
// Parameters:
//   SCAN_DIV   clock cycles each digit stays lit (minimum 2)
//   CNT_W      width of the scan divider counter (SCAN_DIV-1 must fit)
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-low reset
//   nibble_in   serializer data nibble
//   sync_in     frame marker, high on the most-significant nibble
//   seg[6:0]    segment drive, active-low, order g,f,e,d,c,b,a
//   an[3:0]     digit enables, active-low, an[0] = least-significant digit
//   frame_done  one-cycle pulse when a full frame is committed
//   frame_err   one-cycle pulse when a partial frame is discarded
//
// Build option:
//   SEG7_BLANK_LEADING_ZERO_EN  when defined, digits 3..1 are blanked while
//                               they and all more-significant digits are 0.
//                               Digit 0 is never blanked.

module seg7_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] nibble_in,
  input  logic       sync_in,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [CNT_W-1:0] DIV_MAX = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    N1,
    N2,
    N3
  } cap_state_t;

  cap_state_t  state;
  cap_state_t  state_nxt;
  logic [15:0] shift;
  logic [15:0] shift_nxt;
  logic [15:0] disp_buf;
  logic        commit;
  logic        restart;

  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       digit_idx;
  logic             div_wrap;
  logic [1:0]       idx_nxt;
  logic [3:0]       cur_nibble;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Capture next-state logic. A sync always wins and restarts the frame;
  // leaving a partially filled frame that way is reported as an error.
  // Only the N3 step commits, so disp_buf never sees a torn frame.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    commit    = 1'b0;
    restart   = 1'b0;
    if (sync_in) begin
      state_nxt         = N1;
      shift_nxt[15:12]  = nibble_in;
      restart           = (state != IDLE);
    end else begin
      case (state)
        N1: begin
          shift_nxt[11:8] = nibble_in;
          state_nxt       = N2;
        end
        N2: begin
          shift_nxt[7:4] = nibble_in;
          state_nxt      = N3;
        end
        N3: begin
          shift_nxt[3:0] = nibble_in;
          commit         = 1'b1;
          state_nxt      = IDLE;
        end
        default: ;
      endcase
    end
  end

  // Capture registers. The commit writes the freshly completed word
  // (including the last nibble sampled on this same edge).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      shift      <= 16'h0000;
      disp_buf   <= 16'h0000;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift      <= shift_nxt;
      frame_done <= commit;
      frame_err  <= restart;
      if (commit) begin
        disp_buf <= shift_nxt;
      end
    end
  end

  // Scan selection. an and seg are both computed from the digit index the
  // counter is about to hold, so the enable and its segments always
  // change together on the same edge.
  always_comb begin
    div_wrap = (div_cnt == DIV_MAX);
    idx_nxt  = div_wrap ? digit_idx + 2'd1 : digit_idx;
    an_nxt   = ~(4'b0001 << idx_nxt);
    case (idx_nxt)
      2'd0:    cur_nibble = disp_buf[3:0];
      2'd1:    cur_nibble = disp_buf[7:4];
      2'd2:    cur_nibble = disp_buf[11:8];
      default: cur_nibble = disp_buf[15:12];
    endcase
  end

`ifdef SEG7_BLANK_LEADING_ZERO_EN
  logic blank;

  // A digit is a leading zero when it and everything above it are zero.
  always_comb begin
    blank = 1'b0;
    case (idx_nxt)
      2'd3:    blank = (disp_buf[15:12] == 4'h0);
      2'd2:    blank = (disp_buf[15:8] == 8'h00);
      2'd1:    blank = (disp_buf[15:4] == 12'h000);
      default: blank = 1'b0;
    endcase
    seg_nxt = blank ? 7'b1111111 : hex_decode(cur_nibble);
  end
`else
  always_comb begin
    seg_nxt = hex_decode(cur_nibble);
  end
`endif

  // Free-running scan divider and registered display outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt   <= '0;
      digit_idx <= 2'd0;
      an        <= 4'b1110;
      seg       <= 7'b1000000;
    end else begin
      div_cnt   <= div_wrap ? '0 : div_cnt + CNT_W'(1);
      digit_idx <= idx_nxt;
      an        <= an_nxt;
      seg       <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan
// ------------
// Self-checking bench for seg7_scan with SCAN_DIV=4. A table of capture
// vectors checks frame_done/frame_err per cycle, and selected vectors
// follow up with a full refresh period that checks every digit's segments
// and dwell time against the expected buffer contents. Hand-written
// sequences cover reset behaviour and the leading-zero frame.

module tb_seg7_scan;

  localparam int SCAN_DIV = 4;
  localparam int CNT_W    = 4;

  logic       clk;
  logic       reset;
  logic [3:0] nibble_in;
  logic       sync_in;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_done;
  logic       frame_err;

  int n_checks;
  int n_pass;

  typedef struct {
    logic        sync;
    logic [3:0]  nib;
    logic        exp_done;
    logic        exp_err;
    logic        chk_scan;
    logic [15:0] exp_buf;
  } vec_t;

  vec_t vecs[$];

  seg7_scan #(
    .SCAN_DIV(SCAN_DIV),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .nibble_in (nibble_in),
    .sync_in   (sync_in),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low segment patterns for hex digits 0-F.
  function automatic logic [6:0] segOf(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] expSeg(input logic [15:0] b, input int d);
    logic [15:0] upper;
    logic [3:0]  nib;
    upper = b >> (4 * d);
    nib   = upper[3:0];
`ifdef SEG7_BLANK_LEADING_ZERO_EN
    if (d != 0 && upper == 16'h0000) return 7'b1111111;
`endif
    return segOf(nib);
  endfunction

  function automatic void addVec(input logic s, input logic [3:0] n,
                                 input logic d, input logic e,
                                 input logic c, input logic [15:0] b);
    vec_t v;
    v.sync = s; v.nib = n; v.exp_done = d; v.exp_err = e;
    v.chk_scan = c; v.exp_buf = b;
    vecs.push_back(v);
  endfunction

  // Drive inputs, take one rising edge, then settle past the edge so the
  // caller samples the registered outputs produced by that edge.
  task automatic applyStimulus(input logic rst_n, input logic s, input logic [3:0] n);
    reset     = rst_n;
    sync_in   = s;
    nibble_in = n;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Watch one full refresh period with no capture activity. Every digit
  // must be lit for exactly SCAN_DIV cycles, show the expected pattern on
  // every cycle it is lit, and no frame flag may pulse.
  task automatic scanCheck(input string tag, input logic [15:0] b);
    int cnt[4];
    logic [6:0] seen[4];
    int bad_an;
    int flags;
    int d;
    bad_an = 0;
    flags  = 0;
    for (int i = 0; i < 4; i++) begin
      cnt[i]  = 0;
      seen[i] = expSeg(b, i);
    end
    for (int c = 0; c < 4 * SCAN_DIV; c++) begin
      applyStimulus(1'b1, 1'b0, 4'h0);
      case (an)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        default: d = -1;
      endcase
      if (d < 0) bad_an++;
      else begin
        cnt[d]++;
        if (seg !== expSeg(b, d)) seen[d] = seg;
      end
      if (frame_done !== 1'b0 || frame_err !== 1'b0) flags++;
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s digit%0d seg", tag, i), 16'(seen[i]), 16'(expSeg(b, i)));
      checkOutput($sformatf("%s digit%0d dwell", tag, i), 16'(cnt[i]), 16'(SCAN_DIV));
    end
    checkOutput($sformatf("%s invalid an", tag), 16'(bad_an), 16'd0);
    checkOutput($sformatf("%s stray flags", tag), 16'(flags), 16'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b0;
    sync_in   = 1'b0;
    nibble_in = 4'h0;

    // Reset held for two cycles.
    applyStimulus(1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 4'h0);
    checkOutput("reset an", 16'(an), 16'(4'b1110));
    checkOutput("reset seg", 16'(seg), 16'(7'b1000000));
    checkOutput("reset done", 16'(frame_done), 16'd0);
    checkOutput("reset err", 16'(frame_err), 16'd0);
    scanCheck("idle", 16'h0000);

    // Frame 1234, trailing idle nibble ignored.
    addVec(1, 4'h1, 0, 0, 0, 16'h0);
    addVec(0, 4'h2, 0, 0, 0, 16'h0);
    addVec(0, 4'h3, 0, 0, 0, 16'h0);
    addVec(0, 4'h4, 1, 0, 1, 16'h1234);
    addVec(0, 4'h9, 0, 0, 1, 16'h1234);
    // Restart from N2: 56xx is discarded.
    addVec(1, 4'h5, 0, 0, 0, 16'h0);
    addVec(0, 4'h6, 0, 0, 0, 16'h0);
    addVec(1, 4'hA, 0, 1, 0, 16'h0);
    addVec(0, 4'hB, 0, 0, 0, 16'h0);
    addVec(0, 4'hC, 0, 0, 0, 16'h0);
    addVec(0, 4'hD, 1, 0, 1, 16'hABCD);
    // Back-to-back 5678 then F00F.
    addVec(1, 4'h5, 0, 0, 0, 16'h0);
    addVec(0, 4'h6, 0, 0, 0, 16'h0);
    addVec(0, 4'h7, 0, 0, 0, 16'h0);
    addVec(0, 4'h8, 1, 0, 0, 16'h0);
    addVec(1, 4'hF, 0, 0, 0, 16'h0);
    addVec(0, 4'h0, 0, 0, 0, 16'h0);
    addVec(0, 4'h0, 0, 0, 0, 16'h0);
    addVec(0, 4'hF, 1, 0, 1, 16'hF00F);
    // Restart from N3.
    addVec(1, 4'h9, 0, 0, 0, 16'h0);
    addVec(0, 4'h9, 0, 0, 0, 16'h0);
    addVec(0, 4'h9, 0, 0, 0, 16'h0);
    addVec(1, 4'h3, 0, 1, 0, 16'h0);
    addVec(0, 4'h2, 0, 0, 0, 16'h0);
    addVec(0, 4'h1, 0, 0, 0, 16'h0);
    addVec(0, 4'h0, 1, 0, 1, 16'h3210);
    // Restart from N1.
    addVec(1, 4'hE, 0, 0, 0, 16'h0);
    addVec(1, 4'hC, 0, 1, 0, 16'h0);
    addVec(0, 4'h8, 0, 0, 0, 16'h0);
    addVec(0, 4'h6, 0, 0, 0, 16'h0);
    addVec(0, 4'h4, 1, 0, 1, 16'hC864);

    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].sync, vecs[i].nib);
      checkOutput($sformatf("vec%0d done", i), 16'(frame_done), 16'(vecs[i].exp_done));
      checkOutput($sformatf("vec%0d err", i), 16'(frame_err), 16'(vecs[i].exp_err));
      if (vecs[i].chk_scan) scanCheck($sformatf("vec%0d", i), vecs[i].exp_buf);
    end

    // Reset in N2: frame dropped silently, trailing nibbles ignored.
    applyStimulus(1'b1, 1'b1, 4'h1);
    applyStimulus(1'b1, 1'b0, 4'h2);
    applyStimulus(1'b0, 1'b0, 4'h3);
    checkOutput("midrst an", 16'(an), 16'(4'b1110));
    checkOutput("midrst seg", 16'(seg), 16'(7'b1000000));
    checkOutput("midrst done", 16'(frame_done), 16'd0);
    checkOutput("midrst err", 16'(frame_err), 16'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 4'(4 + k));
      checkOutput($sformatf("midrst tail%0d done", k), 16'(frame_done), 16'd0);
      checkOutput($sformatf("midrst tail%0d err", k), 16'(frame_err), 16'd0);
    end
    scanCheck("midrst", 16'h0000);

    // Leading-zero frame 0040.
    applyStimulus(1'b1, 1'b1, 4'h0);
    applyStimulus(1'b1, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 4'h4);
    applyStimulus(1'b1, 1'b0, 4'h0);
    checkOutput("f0040 done", 16'(frame_done), 16'd1);
    scanCheck("f0040", 16'h0040);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Display back-end for the calculator. It consumes the serialized nibble stream produced by the display serializer (`display_out`/`sync`), reassembles each 4-nibble frame into a 16-bit display buffer, and time-multiplexes the buffer onto a 4-digit common-anode 7-segment display. It sits directly downstream of the serializer and drives the board pins.

## Interface

Parameters:
- `SCAN_DIV`, default 50000: clock cycles each digit stays lit. Minimum legal value is 2.
- `CNT_W`, default 16: width of the scan divider counter. The integrator must set it so that `SCAN_DIV-1` fits in `CNT_W` bits.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `nibble_in` input 4: serializer data (`display_out`).
- `sync_in` input 1: serializer frame marker (`sync`). When high, it marks the most-significant nibble of a frame.
- `seg` output 7: segment drive, active-low. `seg[6:0]` maps to g,f,e,d,c,b,a.
- `an` output 4: digit enables, active-low. `an[0]` is the least-significant digit.
- `frame_done` output 1: one-cycle pulse when a complete frame is committed to the buffer.
- `frame_err` output 1: one-cycle pulse when a partial frame is discarded.

## Operation

Capture FSM:
- States are IDLE, N1, N2, N3.
- In any state, `sync_in`=1 samples `nibble_in` into `shift[15:12]` and moves to N1. This includes a sync while in N1, N2 or N3, which restarts the frame.
- N1 with no sync: sample into `[11:8]`, go to N2.
- N2 with no sync: sample into `[7:4]`, go to N3.
- N3 with no sync: sample into `[3:0]`, commit the full 16 bits to `disp_buf`, pulse `frame_done`, return to IDLE.
- IDLE with no sync: ignore `nibble_in`.
- Restarting from N1, N2 or N3 discards the partial frame and pulses `frame_err`. `disp_buf` is left unchanged.
- `disp_buf` is only ever updated on a complete commit, so the display never shows a torn frame.

Scan:
- `div_cnt` counts 0..`SCAN_DIV-1`. When it wraps to 0, `digit_idx` (2 bits) increments 0→1→2→3→0.
- `an` = one-hot-low of `digit_idx`.
- `seg` = hex decode of `disp_buf[4*digit_idx +: 4]`.
- Decode, active-low, values 0-F:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- `an` and `seg` are registered and change on the same edge. Scanning is free-running and independent of capture.

## Timing

Reset values (`reset`=0 at a rising edge):
- FSM = IDLE; `shift`=0; `disp_buf`=16'h0000.
- `div_cnt`=0; `digit_idx`=0.
- `an`=4'b1110; `seg`=7'b1000000.
- `frame_done`=0; `frame_err`=0.
- Reset mid-frame drops the frame with no `frame_err` pulse.

Capture latency:
- The sync nibble is sampled at edge E0; the following nibbles at E1, E2, E3.
- `disp_buf` updates at E3, and `frame_done` is high during the cycle E3→E4.
- New digits are visible when that digit is next scanned. It is visible on the next edge if it is already the active digit.

Back-to-back frames: a sync at E4, immediately after a commit, is legal and produces no `frame_err`.

Scan period: each digit is lit for exactly `SCAN_DIV` cycles; a full refresh takes `4*SCAN_DIV` cycles.

## Configuration

- `SEG7_BLANK_LEADING_ZERO_EN` defined:
  - Digits 3, 2, 1 are blanked (`seg`=7'b1111111, `an` still scans) while they and every more-significant digit are 0.
  - Digit 0 is never blanked. Example: 16'h0040 displays "  40".
- Not defined: all four digits always show their hex value, including leading zeros.

## Test plan

All scenarios use `SCAN_DIV`=4.

- Reset held for 2 cycles, then released with no stimulus → `an`=1110, `seg`=1000000 (0); `an` steps 1101, 1011, 0111, 1110 every 4 cycles; `frame_done`=0.
- Stream `sync_in`=1 with nibbles 1,2,3,4 on consecutive cycles → `disp_buf`=16'h1234 and `frame_done` pulses once, one cycle after the 4th nibble. Over one scan, digit 0 shows 4 (0011001) and digit 3 shows 1 (1111001).
- Sync+5, 6, then sync+A, B, C, D → `frame_err` pulses once at the restart; `disp_buf`=16'hABCD; 16'h56xx never appears.
- Two back-to-back frames, 16'h5678 then 16'hF00F, with no gap → two `frame_done` pulses and no `frame_err`; final `disp_buf`=16'hF00F, digit 3 `seg`=0001110.
- Assert reset during N2 of a frame → outputs return to reset values next edge; `disp_buf`=0; the trailing nibbles without sync are ignored.
- With `SEG7_BLANK_LEADING_ZERO_EN`, send frame 16'h0040 → digits 3 and 2 show `seg`=1111111, digit 1 shows 4, digit 0 shows 0. Without the macro, digits 3 and 2 show 1000000.
